// File: rtl/matmul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matmul_pkg : shared types and latency helpers for matmul_stream      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package matmul_pkg;

  typedef struct packed {
    int rows;
    int cols;
  } matmul_dims_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    CALCULATE = 3'd2,
    WRITE     = 3'd3,
    ERROR     = 3'd4
  } matmul_state_t;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    ZERO_DIM  = 2'd1,
    MISMATCH  = 2'd2,
    TOO_LARGE = 2'd3
  } matmul_err_t;

  function automatic int matmul_read_time(input matmul_dims_t a, input matmul_dims_t b);
    int ea;
    int eb;
    ea = a.rows * a.cols;
    eb = b.rows * b.cols;
    return (ea > eb) ? ea : eb;
  endfunction

  function automatic int matmul_compute_time(input matmul_dims_t a, input matmul_dims_t b);
    return a.rows * b.cols * a.cols;
  endfunction

  function automatic int matmul_write_time(input matmul_dims_t a, input matmul_dims_t b);
    return a.rows * b.cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matmul_mac : signed multiply-accumulate with clear, DATA_W convert   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module matmul_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] res,
  output logic                     fits
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    sum;
  logic [ACC_W-DATA_W:0]      hi;

  // res/fits describe the running sum including this cycle's product
  always_comb begin
    prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    sum   = (clear ? '0 : acc_q) + ACC_W'(prod);
    acc_d = en ? sum : acc_q;
    hi    = sum[ACC_W-1:DATA_W-1];
    fits  = (hi == '0) || (&hi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  if (SAT != 0) begin : g_sat
    always_comb begin
      if (fits) begin
        res = sum[DATA_W-1:0];
      end else if (sum[ACC_W-1]) begin
        res = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        res = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end else begin : g_trunc
    assign res = sum[DATA_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/matmul_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matmul_stream : streaming C = A x B with valid/ready channels        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module matmul_stream
  import matmul_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 64,
  parameter int MAX_ELS = 256,
  parameter int SAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  matmul_dims_t      dims_a,
  input  matmul_dims_t      dims_b,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output matmul_state_t     state,
  output matmul_err_t       err,
  output logic              ovf,
  output logic              done
);

  localparam int            CW    = $clog2(MAX_ELS + 1);
  localparam int            AW    = (MAX_ELS > 1) ? $clog2(MAX_ELS) : 1;
  localparam int            PW    = 2 * CW;
  localparam logic [31:0]   MAX_U = 32'(MAX_ELS);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_ELS);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] ZERO  = '0;

  matmul_state_t state_q, state_d;
  matmul_err_t   err_q, err_d;
  logic          ovf_q, ovf_d, done_q, done_d;

  logic [CW-1:0] cols_a_q, cols_a_d, cols_b_q, cols_b_d;
  logic [CW-1:0] els_a_q, els_a_d, els_b_q, els_b_d, els_c_q, els_c_d;
  logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [CW-1:0] k_q, k_d, j_q, j_d, a_base_q, a_base_d;
  logic [CW-1:0] b_idx_q, b_idx_d, c_idx_q, c_idx_d, out_idx_q, out_idx_d;

  logic [DATA_W-1:0] a_mem [MAX_ELS];
  logic [DATA_W-1:0] b_mem [MAX_ELS];
  logic [DATA_W-1:0] c_mem [MAX_ELS];

  logic [31:0]   ra, ca, rb, cb;
  logic [CW-1:0] ra_n, ca_n, rb_n, cb_n;
  logic [PW-1:0] els_a_w, els_b_w, els_c_w;
  logic          dim_zero, dim_mis, dim_big, go;

  logic          a_fire, b_fire, out_fire, a_done_nxt, b_done_nxt;
  logic          calc, k_last, j_last, c_last, store, out_last;
  logic [CW-1:0] a_rd_idx, cols_a_m1, cols_b_m1, els_a_m1, els_b_m1, els_c_m1;
  logic [DATA_W-1:0] a_op, b_op, mac_res;
  logic          mac_fits;

  // Any single dimension above MAX_ELS already makes one of the products
  // too large, so the products only need CW-bit operands.
  always_comb begin
    ra       = dims_a.rows;
    ca       = dims_a.cols;
    rb       = dims_b.rows;
    cb       = dims_b.cols;
    ra_n     = ra[CW-1:0];
    ca_n     = ca[CW-1:0];
    rb_n     = rb[CW-1:0];
    cb_n     = cb[CW-1:0];
    els_a_w  = PW'(ra_n) * PW'(ca_n);
    els_b_w  = PW'(rb_n) * PW'(cb_n);
    els_c_w  = PW'(ra_n) * PW'(cb_n);
    dim_zero = (ra == '0) || (ca == '0) || (rb == '0) || (cb == '0);
    dim_mis  = (ca != rb);
    dim_big  = (ra > MAX_U) || (ca > MAX_U) || (rb > MAX_U) || (cb > MAX_U) ||
               (els_a_w > MAX_P) || (els_b_w > MAX_P) || (els_c_w > MAX_P);
    go       = (state_q == IDLE) && start && !dim_zero && !dim_mis && !dim_big;
  end

  always_comb begin
    cols_a_m1  = cols_a_q - ONE;
    cols_b_m1  = cols_b_q - ONE;
    els_a_m1   = els_a_q - ONE;
    els_b_m1   = els_b_q - ONE;
    els_c_m1   = els_c_q - ONE;
    a_fire     = a_ready && a_valid;
    b_fire     = b_ready && b_valid;
    out_fire   = out_valid && out_ready;
    a_done_nxt = (a_cnt_q == els_a_q) || (a_fire && (a_cnt_q == els_a_m1));
    b_done_nxt = (b_cnt_q == els_b_q) || (b_fire && (b_cnt_q == els_b_m1));
    calc       = (state_q == CALCULATE);
    k_last     = (k_q == cols_a_m1);
    j_last     = (j_q == cols_b_m1);
    c_last     = (c_idx_q == els_c_m1);
    store      = calc && k_last;
    out_last   = (out_idx_q == els_c_m1);
    a_rd_idx   = a_base_q + k_q;
    a_op       = a_mem[a_rd_idx[AW-1:0]];
    b_op       = b_mem[b_idx_q[AW-1:0]];
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT    (SAT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en    (calc),
    .clear (k_q == ZERO),
    .a     (a_op),
    .b     (b_op),
    .res   (mac_res),
    .fits  (mac_fits)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (dim_zero) begin
            state_d = ERROR;
            err_d   = ZERO_DIM;
          end else if (dim_mis) begin
            state_d = ERROR;
            err_d   = MISMATCH;
          end else if (dim_big) begin
            state_d = ERROR;
            err_d   = TOO_LARGE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:      if (a_done_nxt && b_done_nxt) state_d = CALCULATE;
      CALCULATE: if (k_last && c_last) state_d = WRITE;
      WRITE:     if (out_fire && out_last) state_d = IDLE;
      ERROR: begin
        if (!start) begin
          state_d = IDLE;
          err_d   = NONE;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = NONE;
      end
    endcase
  end

  always_comb begin
    state     = state_q;
    err       = err_q;
    ovf       = ovf_q;
    done      = done_q;
    a_ready   = (state_q == READ) && (a_cnt_q != els_a_q);
    b_ready   = (state_q == READ) && (b_cnt_q != els_b_q);
    out_valid = (state_q == WRITE);
    out_data  = out_valid ? c_mem[out_idx_q[AW-1:0]] : '0;
  end

  // Inner index k walks the dot product; b_idx strides by cols_b alongside it.
  always_comb begin
    cols_a_d  = cols_a_q;
    cols_b_d  = cols_b_q;
    els_a_d   = els_a_q;
    els_b_d   = els_b_q;
    els_c_d   = els_c_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    k_d       = k_q;
    j_d       = j_q;
    a_base_d  = a_base_q;
    b_idx_d   = b_idx_q;
    c_idx_d   = c_idx_q;
    out_idx_d = out_idx_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    if (go) begin
      cols_a_d  = ca_n;
      cols_b_d  = cb_n;
      els_a_d   = els_a_w[CW-1:0];
      els_b_d   = els_b_w[CW-1:0];
      els_c_d   = els_c_w[CW-1:0];
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      k_d       = '0;
      j_d       = '0;
      a_base_d  = '0;
      b_idx_d   = '0;
      c_idx_d   = '0;
      out_idx_d = '0;
      ovf_d     = 1'b0;
    end
    if (a_fire) a_cnt_d = a_cnt_q + ONE;
    if (b_fire) b_cnt_d = b_cnt_q + ONE;
    if (calc) begin
      if (k_last) begin
        k_d     = '0;
        c_idx_d = c_idx_q + ONE;
        if (!mac_fits) ovf_d = 1'b1;
        if (j_last) begin
          j_d      = '0;
          b_idx_d  = '0;
          a_base_d = a_base_q + cols_a_q;
        end else begin
          j_d     = j_q + ONE;
          b_idx_d = j_q + ONE;
        end
      end else begin
        k_d     = k_q + ONE;
        b_idx_d = b_idx_q + cols_b_q;
      end
    end
    if (out_fire) begin
      out_idx_d = out_idx_q + ONE;
      if (out_last) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_a_q  <= '0;
      cols_b_q  <= '0;
      els_a_q   <= '0;
      els_b_q   <= '0;
      els_c_q   <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      k_q       <= '0;
      j_q       <= '0;
      a_base_q  <= '0;
      b_idx_q   <= '0;
      c_idx_q   <= '0;
      out_idx_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cols_a_q  <= cols_a_d;
      cols_b_q  <= cols_b_d;
      els_a_q   <= els_a_d;
      els_b_q   <= els_b_d;
      els_c_q   <= els_c_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      k_q       <= k_d;
      j_q       <= j_d;
      a_base_q  <= a_base_d;
      b_idx_q   <= b_idx_d;
      c_idx_q   <= c_idx_d;
      out_idx_q <= out_idx_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (a_fire) a_mem[a_cnt_q[AW-1:0]] <= a_data;
    if (b_fire) b_mem[b_cnt_q[AW-1:0]] <= b_data;
    if (store)  c_mem[c_idx_q[AW-1:0]] <= mac_res;
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matmul_stream : directed bench with a reference matrix model      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_matmul_stream;
  import matmul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          start, a_valid, b_valid, out_ready;
  matmul_dims_t  dims_a, dims_b;
  logic [31:0]   a_data, b_data, out_data;
  logic          a_ready, b_ready, out_valid, ovf, done;
  matmul_state_t state;
  matmul_err_t   err;

  matmul_stream #(.DATA_W(32), .ACC_W(64), .MAX_ELS(256), .SAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .dims_a(dims_a), .dims_b(dims_b),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .state(state), .err(err), .ovf(ovf), .done(done));

  // Two 8-bit instances share stimulus: one saturating, one truncating.
  logic          s_start, s_a_valid, s_b_valid, s_out_ready;
  matmul_dims_t  s_dims;
  logic [7:0]    s_a_data, s_b_data, s_out_data, t_out_data;
  logic          s_a_ready, s_b_ready, s_out_valid, s_ovf, s_done;
  logic          t_a_ready, t_b_ready, t_out_valid, t_ovf, t_done;
  matmul_state_t s_state, t_state;
  matmul_err_t   s_err, t_err;

  matmul_stream #(.DATA_W(8), .ACC_W(16), .MAX_ELS(4), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .dims_a(s_dims), .dims_b(s_dims),
    .a_valid(s_a_valid), .a_data(s_a_data), .a_ready(s_a_ready),
    .b_valid(s_b_valid), .b_data(s_b_data), .b_ready(s_b_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .state(s_state), .err(s_err), .ovf(s_ovf), .done(s_done));

  matmul_stream #(.DATA_W(8), .ACC_W(16), .MAX_ELS(4), .SAT(0)) dut_trunc (
    .clk(clk), .rst(rst), .start(s_start), .dims_a(s_dims), .dims_b(s_dims),
    .a_valid(s_a_valid), .a_data(s_a_data), .a_ready(t_a_ready),
    .b_valid(s_b_valid), .b_data(s_b_data), .b_ready(t_b_ready),
    .out_valid(t_out_valid), .out_data(t_out_data), .out_ready(s_out_ready),
    .state(t_state), .err(t_err), .ovf(t_ovf), .done(t_done));

  int     total = 0;
  int     bad   = 0;
  int     ma[$];
  int     mb[$];
  longint exp_q[$];
  longint got_q[$];

  function automatic void chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endfunction

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Scoreboard: every accepted C element must be the next model value, and
  // a stalled element must stay valid and unchanged until accepted.
  logic        held_pend = 1'b0;
  logic [31:0] held_val  = '0;
  always @(negedge clk) begin
    if (rst) begin
      held_pend = 1'b0;
    end else begin
      if (held_pend) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_data", $signed(out_data), $signed(held_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_output", 1, 0);
        else chk("c_value", $signed(out_data), exp_q.pop_front());
        got_q.push_back(longint'($signed(out_data)));
      end
      held_pend = out_valid && !out_ready;
      held_val  = out_data;
    end
  end

  task automatic run_mm(input int ra, input int ca, input int cb, input int b_per,
                        input int rdy_per, output int rd, output int cc,
                        output int wc, output bit sd);
    int     ai;
    int     bi;
    longint s;
    for (int i = 0; i < ra; i++) begin
      for (int j = 0; j < cb; j++) begin
        s = 0;
        for (int k = 0; k < ca; k++) s += longint'(ma[i*ca+k]) * longint'(mb[k*cb+j]);
        exp_q.push_back(clamp32(s));
      end
    end
    rd = 0; cc = 0; wc = 0; sd = 1'b0; ai = 0; bi = 0;
    @(posedge clk); #1;
    dims_a = '{rows: ra, cols: ca};
    dims_b = '{rows: ca, cols: cb};
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !sd; cyc++) begin
      a_valid = (ai < ra*ca);
      a_data  = '0;
      if (a_valid) a_data = ma[ai];
      b_valid = (bi < ca*cb) && (cyc % b_per == 0);
      b_data  = '0;
      if (b_valid) b_data = mb[bi];
      out_ready = (cyc % rdy_per == 0);
      @(negedge clk);
      if (state == READ) rd++;
      if (state == CALCULATE) cc++;
      if (state == WRITE) wc++;
      if (done) sd = 1'b1;
      if (a_valid && a_ready) ai++;
      if (b_valid && b_ready) bi++;
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    if (!sd) chk("done_timeout", 0, 1);
  endtask

  task automatic try_err(input int ra, input int ca, input int rb, input int cb,
                         input int want, input string nm);
    @(posedge clk); #1;
    dims_a = '{rows: ra, cols: ca};
    dims_b = '{rows: rb, cols: cb};
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_state"}, longint'(state), longint'(ERROR));
    chk({nm, "_err"}, longint'(err), want);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_hold"}, longint'(state), longint'(ERROR));
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_idle"}, longint'(state), longint'(IDLE));
    chk({nm, "_clear"}, longint'(err), longint'(NONE));
  endtask

  task automatic run8(input int av, input int bv, input int want_s, input int want_t,
                      input int want_ovf);
    bit seen;
    @(posedge clk); #1;
    s_dims  = '{rows: 1, cols: 1};
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_a_valid = 1'b1; s_b_valid = 1'b1; s_out_ready = 1'b1;
    s_a_data = 8'(av); s_b_data = 8'(bv);
    @(posedge clk); #1;
    s_a_valid = 1'b0; s_b_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (s_out_valid) begin
        chk("sat_out", $signed(s_out_data), want_s);
        chk("trunc_out", $signed(t_out_data), want_t);
        seen = 1'b1;
      end
    end
    if (!seen) chk("out8_timeout", 0, 1);
    @(negedge clk);
    chk("sat_done", longint'(s_done), 1);
    chk("sat_ovf", longint'(s_ovf), want_ovf);
    chk("trunc_ovf", longint'(t_ovf), want_ovf);
  endtask

  task automatic check_got(input int n, input longint w0, input longint w1,
                           input longint w2, input longint w3, input string nm);
    longint w[4];
    w = '{w0, w1, w2, w3};
    chk({nm, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) chk({nm, "_lit"}, (i < got_q.size()) ? got_q[i] : -1, w[i]);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  int rd, cc, wc;
  bit sd;

  initial begin
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0; dims_a = '0; dims_b = '0;
    s_start = 1'b0; s_a_valid = 1'b0; s_b_valid = 1'b0; s_out_ready = 1'b0;
    s_a_data = '0; s_b_data = '0; s_dims = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", longint'(state), longint'(IDLE));
    chk("rst_err", longint'(err), longint'(NONE));
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ready", longint'({a_ready, b_ready, out_valid}), 0);
    chk("rst_data", longint'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    try_err(1000, 1000, 1000, 1000, TOO_LARGE, "big");
    try_err(16, 16, 16, 17, TOO_LARGE, "prod");
    try_err(2, 3, 4, 2, MISMATCH, "mis");
    try_err(0, 2, 2, 2, ZERO_DIM, "zero");

    ma = '{1, 2, 3, 4};
    mb = '{1, 2, 3, 4};
    got_q.delete();
    run_mm(2, 2, 2, 1, 1, rd, cc, wc, sd);
    chk("r2_read", rd, 4);
    chk("r2_calc", cc, 8);
    chk("r2_write", wc, 4);
    chk("r2_ovf", longint'(ovf), 0);
    check_got(4, 7, 10, 15, 22, "r2");

    ma = '{1, 2, 3, 4, 5, 6};
    mb = '{1, 1, 1};
    got_q.delete();
    run_mm(2, 3, 1, 2, 1, rd, cc, wc, sd);
    chk("r3_read", rd, 6);
    chk("r3_calc", cc, 6);
    check_got(2, 6, 15, 0, 0, "r3");

    ma = '{1, 2, 3, 4};
    mb = '{1, 2, 3, 4};
    got_q.delete();
    run_mm(2, 2, 2, 1, 3, rd, cc, wc, sd);
    chk("bp_write", wc, 10);
    check_got(4, 7, 10, 15, 22, "bp");

    // Reset while CALCULATE is in progress.
    @(posedge clk); #1;
    dims_a = '{rows: 2, cols: 2};
    dims_b = '{rows: 2, cols: 2};
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      a_data = ma[n]; b_data = mb[n];
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_calc", longint'(state), longint'(CALCULATE));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", longint'(state), longint'(IDLE));
    chk("mid_rst_ready", longint'({a_ready, b_ready, out_valid}), 0);
    chk("mid_rst_data", longint'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    run_mm(2, 2, 2, 1, 1, rd, cc, wc, sd);
    check_got(4, 7, 10, 15, 22, "after_rst");

    run8(100, 100, 127, 16, 1);
    run8(-100, 100, -128, -16, 1);
    run8(5, -3, -15, -15, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/matmul_stream.md
Name: matmul_stream

Overview:
- Parametrised successor to the fixed-width integer matrix multiplier: computes C = A x B for signed DATA_W-bit elements.
- Matrices A and B stream in row-major over independent valid/ready channels; C streams out row-major with backpressure.
- Accumulation is ACC_W bits; the output is saturated or truncated according to a parameter.
- Sits between a host DMA/stream source and a result sink. It keeps the IDLE/READ/CALCULATE/WRITE/ERROR sequencing of the existing matmul.

Parameters:
- DATA_W, 32, signed element width for A, B and C.
- ACC_W, 64, signed accumulator width; must be >= 2*DATA_W.
- MAX_ELS, 256, capacity in elements of each internal buffer (A, B, C).
- SAT, 1, 1 = saturate the ACC_W result to DATA_W on output; 0 = keep the low DATA_W bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request an operation; sampled in IDLE
- dims_a  in  matmul_dims_t  rows/cols of A; sampled with start
- dims_b  in  matmul_dims_t  rows/cols of B; sampled with start
- a_valid  in  1  A element valid
- a_data  in  DATA_W  A element
- a_ready  out  1  A element accepted
- b_valid  in  1  B element valid
- b_data  in  DATA_W  B element
- b_ready  out  1  B element accepted
- out_valid  out  1  C element valid
- out_data  out  DATA_W  C element
- out_ready  in  1  sink accepts C element
- state  out  matmul_state_t  current state
- err  out  matmul_err_t  error cause; NONE unless state == ERROR
- ovf  out  1  sticky overflow/saturation flag for the current operation
- done  out  1  one-cycle pulse after the last C handshake

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, err=NONE, ovf=0, done=0, a_ready=b_ready=out_valid=0, out_data=0.
  - All counters cleared; buffer contents don't-care.
- IDLE, start=1 at a rising edge: latch dims and validate.
  - rows or cols of A or B == 0 -> ERROR, err=ZERO_DIM.
  - Otherwise dims_a.cols != dims_b.rows -> ERROR, err=MISMATCH.
  - Otherwise rows_a*cols_a, rows_b*cols_b or rows_a*cols_b > MAX_ELS -> ERROR, err=TOO_LARGE.
  - Otherwise -> READ. ovf is cleared at this edge.
- ERROR: remain while start=1; first edge with start=0 -> IDLE, err=NONE.
- READ:
  - a_ready=1 until rows_a*cols_a A handshakes complete; b_ready likewise for B.
  - The two channels are fully independent; simultaneous A and B handshakes are allowed.
  - The edge that completes the last outstanding handshake moves to CALCULATE. Minimum READ duration = max(els_a, els_b) cycles.
- CALCULATE:
  - One MAC per cycle, exactly rows_a*cols_b*cols_a cycles, then WRITE.
  - For each C[i][j], the accumulator clears and then sums cols_a signed products at full ACC_W width.
  - Result stored in the C buffer at i*cols_b+j.
  - Conversion to DATA_W at store time:
    - SAT=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - SAT=0: take the low DATA_W bits.
  - Either mode sets ovf if the value does not fit.
  - ACC_W overflow wraps and is not detected.
- WRITE:
  - out_valid=1, out_data=C[k], starting at k=0.
  - k advances only on out_valid&out_ready; out_data is held stable while out_ready=0.
  - The edge of the final handshake goes to IDLE, with done=1 for that following cycle.
- start is ignored outside IDLE and ERROR.
- Elements presented outside READ, or after a channel's count completes, are not accepted (ready=0).
- Exported helpers:
  - matmul_read_time = max(els_a, els_b)
  - matmul_compute_time = rows_a*cols_b*cols_a
  - matmul_write_time = rows_a*cols_b
  - Latencies hold exactly under continuous valid/ready.

Decomposition:
- matmul_pkg holds:
  - matmul_dims_t {int rows; int cols;}
  - matmul_state_t (IDLE, READ, CALCULATE, WRITE, ERROR)
  - matmul_err_t (NONE, ZERO_DIM, MISMATCH, TOO_LARGE)
  - the matmul_*_time functions
- Sub-module matmul_mac (parameters DATA_W, ACC_W, SAT) handles:
  - the signed multiply and accumulate-with-clear
  - the DATA_W conversion and the fits flag
- The top module holds the FSM, counters and the three buffers.

Test Plan:
- dims_a={1000,1000}, dims_b={1000,1000}, start=1 -> ERROR/TOO_LARGE next cycle; start=0 -> IDLE, err=NONE. Then dims_a={2,3}, dims_b={4,2} -> MISMATCH; dims_a={0,2} -> ZERO_DIM.
- A=B=[[1,2],[3,4]] with continuous valid/ready:
  - READ lasts 4 cycles, CALCULATE 8 cycles.
  - C=7,10,15,22; done pulses; ovf=0.
- A 2x3=[1,2,3;4,5,6], B 3x1=[1,1,1], with A valid on every cycle and B valid every other cycle -> READ completes on the 6th A handshake edge; CALCULATE 6 cycles; C=6,15.
- Output backpressure: out_ready toggled 1,0,0,1,... during the 2x2 case -> each C value held stable until accepted; order 7,10,15,22; no duplicates.
- DATA_W=8, A=[100], B=[100]:
  - SAT=1 -> out 127, ovf=1.
  - SAT=0 -> out 16, ovf=1.
  - A=[-100], B=[100] with SAT=1 -> -128.
- rst asserted during CALCULATE of the 2x2 case -> state=IDLE immediately, all ready/valid=0. A subsequent full 2x2 run produces the correct results.
